div32_iter: RTL and testbench

Iterative 32-bit divider that inverts the operation of the combinational MULT32/MULT32_U multipliers. It takes dividend A and divisor B and produces quotient on LO and remainder on HI, the same HI/LO pairing the multiply path feeds into the HI/LO registers. A restoring shift-subtract datapath resolves one quotient bit per clock, in signed or unsigned mode. It sits beside the multiplier in the ALU complex and exposes a START/BUSY/DONE handshake to the control unit.

---
 rtl/div32_iter_pkg.sv | 20 ++
 rtl/div32_iter_step.sv | 28 ++
 rtl/div32_iter.sv | 138 +++++++++++++
 tb/tb_div32_iter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/div32_iter_pkg.sv
// Shared constants, FSM state type and two's-complement helper for the
// iterative 32-bit divider.
package div32_iter_pkg;

    localparam int unsigned DATA_WIDTH       = 32;
    localparam int unsigned DATA_INDEX_LIMIT = DATA_WIDTH - 1;
    localparam int unsigned DIV_CYCLES       = 33;
    localparam int unsigned CNT_W            = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX
    } div_state_e;

    function automatic logic [DATA_WIDTH-1:0] twos_comp(input logic [DATA_WIDTH-1:0] x);
        return ~x + DATA_WIDTH'(1);
    endfunction

endpackage

// File: rtl/div32_iter_step.sv
// One restoring shift-subtract iteration; the adder carry-out is the
// "trial is non-negative" flag (carry = no borrow).
module div32_step
    import div32_iter_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] rem_i,
    input  logic [DATA_WIDTH-1:0] quo_i,
    input  logic [DATA_WIDTH-1:0] div_i,
    output logic [DATA_WIDTH-1:0] rem_o,
    output logic [DATA_WIDTH-1:0] quo_o
);

    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] diff;
    logic                carry;
    logic                unused_msbs;

    assign shifted = {rem_i, quo_i[DATA_INDEX_LIMIT]};

    // 33-bit subtract as add of inverted operand plus one.
    assign {carry, diff} = {1'b0, shifted} + {1'b0, ~{1'b0, div_i}} + (DATA_WIDTH + 2)'(1);

    // A restored remainder is always below the divisor, so bit 32 is never needed.
    assign rem_o       = carry ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
    assign quo_o       = {quo_i[DATA_WIDTH-2:0], carry};
    assign unused_msbs = diff[DATA_WIDTH] ^ shifted[DATA_WIDTH];

endmodule

// File: rtl/div32_iter.sv
// Iterative signed/unsigned 32-bit divider: quotient on LO, remainder on HI,
// START/BUSY/DONE handshake, one quotient bit per clock.
module div32_iter
    import div32_iter_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  SIGNED,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [DATA_WIDTH-1:0] HI,
    output logic [DATA_WIDTH-1:0] LO,
    output logic                  DIV_BY_ZERO
);

    div_state_e              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rem_q, rem_d;
    logic [DATA_WIDTH-1:0]   quo_q, quo_d;
    logic [DATA_WIDTH-1:0]   div_q, div_d;
    logic [DATA_WIDTH-1:0]   araw_q, araw_d;
    logic                    sgn_q, sgn_d;
    logic                    sa_q, sa_d;
    logic                    sb_q, sb_d;
    logic                    zero_q, zero_d;
    logic [DATA_WIDTH-1:0]   hi_q, hi_d;
    logic [DATA_WIDTH-1:0]   lo_q, lo_d;
    logic                    dbz_q, dbz_d;
    logic                    done_q, done_d;

    logic [DATA_WIDTH-1:0]   step_rem, step_quo;

    div32_step u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (div_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        araw_d  = araw_q;
        sgn_d   = sgn_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        zero_d  = zero_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (START) begin
                    sgn_d   = SIGNED;
                    sa_d    = A[DATA_INDEX_LIMIT];
                    sb_d    = B[DATA_INDEX_LIMIT];
                    zero_d  = (B == '0);
                    araw_d  = A;
                    quo_d   = (SIGNED && A[DATA_INDEX_LIMIT]) ? twos_comp(A) : A;
                    div_d   = (SIGNED && B[DATA_INDEX_LIMIT]) ? twos_comp(B) : B;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DIV_CYCLES - 2))
                    state_d = ST_FIX;
            end
            ST_FIX: begin
                if (zero_q) begin
                    lo_d = '1;
                    hi_d = araw_q;
                end else begin
                    lo_d = (sgn_q && (sa_q ^ sb_q)) ? twos_comp(quo_q) : quo_q;
                    hi_d = (sgn_q && sa_q) ? twos_comp(rem_q) : rem_q;
                end
                dbz_d   = zero_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            araw_q  <= '0;
            sgn_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            zero_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            araw_q  <= araw_d;
            sgn_q   <= sgn_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            zero_q  <= zero_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign BUSY        = (state_q != ST_IDLE);
    assign DONE        = done_q;
    assign HI          = hi_q;
    assign LO          = lo_q;
    assign DIV_BY_ZERO = dbz_q;

endmodule

// File: tb/tb_div32_iter.sv
// Bench for div32_iter: cycle-count reference model checked every cycle,
// plus directed vectors with hand-computed quotient/remainder values.
module tb_div32_iter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        SIGNED = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        BUSY, DONE, DIV_BY_ZERO;
    logic [31:0] HI, LO;

    int checks = 0;
    int errs   = 0;

    div32_iter dut (
        .CLK         (CLK),
        .RST         (RST),
        .START       (START),
        .SIGNED      (SIGNED),
        .A           (A),
        .B           (B),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .HI          (HI),
        .LO          (LO),
        .DIV_BY_ZERO (DIV_BY_ZERO)
    );

    always #5 CLK = ~CLK;

    // Arithmetic reference: truncating divide, remainder follows the dividend.
    function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r, output bit z);
        longint sa, sb, lq, lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
            z  = 1'b0;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    // Behavioural timing model: an accepted request completes 33 edges later.
    bit          armed = 1'b0;
    int          left_m = 0;
    bit          done_m = 1'b0;
    logic [31:0] hi_m = '0, lo_m = '0;
    bit          dbz_m = 1'b0;
    bit          s_m;
    logic [31:0] a_m, b_m;

    always @(posedge CLK) begin
        if (RST) begin
            armed  = 1'b1;
            left_m = 0;
            done_m = 1'b0;
            hi_m   = '0;
            lo_m   = '0;
            dbz_m  = 1'b0;
        end else begin
            done_m = 1'b0;
            if (left_m > 0) begin
                left_m--;
                if (left_m == 0) begin
                    done_m = 1'b1;
                    ref_div(s_m, a_m, b_m, lo_m, hi_m, dbz_m);
                end
            end else if (START) begin
                s_m    = SIGNED;
                a_m    = A;
                b_m    = B;
                left_m = 33;
            end
        end
    end

    always @(negedge CLK) begin
        if (armed) begin
            checks++;
            if (BUSY !== (left_m > 0)) begin
                errs++;
                $display("FAIL model_busy t=%0t got %b want %b", $time, BUSY, (left_m > 0));
            end
            checks++;
            if (DONE !== done_m) begin
                errs++;
                $display("FAIL model_done t=%0t got %b want %b", $time, DONE, done_m);
            end
            checks++;
            if (HI !== hi_m || LO !== lo_m || DIV_BY_ZERO !== dbz_m) begin
                errs++;
                $display("FAIL model_result t=%0t got HI=%h LO=%h Z=%b want HI=%h LO=%h Z=%b",
                         $time, HI, LO, DIV_BY_ZERO, hi_m, lo_m, dbz_m);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b);
        SIGNED = s;
        A      = a;
        B      = b;
        START  = 1'b1;
    endtask

    // Called at the negedge where START was raised; returns at the DONE negedge.
    task automatic finish_op(input string name, input logic [31:0] lo_w, input logic [31:0] hi_w,
                             input bit z_w, input bit disturb);
        int cyc  = 0;
        bit seen = 1'b0;
        while (cyc < 40 && !seen) begin
            @(negedge CLK);
            cyc++;
            if (cyc == 1) START = 1'b0;
            if (disturb && cyc == 5) begin
                START  = 1'b1;
                SIGNED = ~SIGNED;
                A      = ~A;
                B      = B + 32'd3;
            end
            if (disturb && cyc == 6) START = 1'b0;
            if (DONE === 1'b1) seen = 1'b1;
        end
        check({name, "_seen"}, 32'(seen), 32'd1);
        check({name, "_lat"}, 32'(cyc), 32'd34);
        check({name, "_lo"}, LO, lo_w);
        check({name, "_hi"}, HI, hi_w);
        check({name, "_dbz"}, 32'(DIV_BY_ZERO), 32'(z_w));
    endtask

    initial begin
        int ndone;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);

        issue(1'b0, 32'd100, 32'd7);                finish_op("u100_7", 32'd14, 32'd2, 1'b0, 1'b0);
        @(negedge CLK);
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);          finish_op("sm7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
        @(negedge CLK);
        issue(1'b1, 32'd7, 32'hFFFF_FFFE);          finish_op("s7_m2", 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
        @(negedge CLK);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);  finish_op("s_ovf", 32'h8000_0000, 32'd0, 1'b0, 1'b0);
        @(negedge CLK);
        issue(1'b0, 32'hFFFF_FFFF, 32'd1);          finish_op("u_max1", 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
        @(negedge CLK);
        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);  finish_op("u_big", 32'd0, 32'h8000_0000, 1'b0, 1'b0);
        @(negedge CLK);
        issue(1'b1, 32'hFFFF_FF9C, 32'd7);          finish_op("sm100_7", 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0);
        @(negedge CLK);
        issue(1'b0, 32'h0000_1234, 32'd0);          finish_op("u_dz", 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1'b0);
        @(negedge CLK);
        issue(1'b1, 32'h0000_1234, 32'd0);          finish_op("s_dz", 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1'b0);
        @(negedge CLK);
        issue(1'b0, 32'd1000, 32'd33);              finish_op("disturb", 32'd30, 32'd10, 1'b0, 1'b1);

        // Back-to-back: second request raised in the DONE cycle.
        @(negedge CLK);
        issue(1'b0, 32'hDEAD_BEEF, 32'h10);         finish_op("b2b_1", 32'h0DEA_DBEE, 32'h0000_000F, 1'b0, 1'b0);
        issue(1'b1, 32'hFFFF_FC18, 32'hFFFF_FFF9);  finish_op("b2b_2", 32'h0000_008E, 32'hFFFF_FFFA, 1'b0, 1'b0);

        // Reset mid-operation aborts without a DONE.
        @(negedge CLK);
        issue(1'b0, 32'd12345, 32'd6);
        @(negedge CLK);
        START = 1'b0;
        repeat (9) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("abort_busy", 32'(BUSY), 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        ndone = 0;
        repeat (40) begin
            @(negedge CLK);
            if (DONE === 1'b1) ndone++;
        end
        check("abort_nodone", 32'(ndone), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
        $finish;
    end

endmodule
